// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_pkg
//  Purpose  : Shared access-size encodings and arbiter state type for the
//             data/instruction RAM port.
//  Revision : 1.0 - initial release
// ============================================================================
package mem_pkg;

    localparam logic [1:0] MASK_BYTE = 2'b00;
    localparam logic [1:0] MASK_HALF = 2'b01;
    localparam logic [1:0] MASK_WORD = 2'b10;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

    // Either encoding with the upper bit set is a word access.
    function automatic logic is_word(input logic [1:0] mask);
        return mask[1];
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_align_check.sv
`default_nettype none
// ============================================================================
//  Module   : mem_align_check
//  Purpose  : Combinational alignment and address-range fault detection.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_align_check
    import mem_pkg::*;
#(
    parameter int MEM_WORDS_LOG2 = 11
) (
    input  logic [31:0] addr,
    input  logic [1:0]  mask,
    output logic        fault
);

    localparam int c_range_lsb = MEM_WORDS_LOG2 + 2;

    logic w_align_fault;
    logic w_range_fault;
    logic w_unused_bits;

    assign w_align_fault = (is_word(mask) && (addr[1:0] != 2'b00)) ||
                           ((mask == MASK_HALF) && addr[0]);

    generate
        if (c_range_lsb < 32) begin : g_range
            assign w_range_fault = |addr[31:c_range_lsb];
        end else begin : g_no_range
            assign w_range_fault = 1'b0;
        end
    endgenerate

    // Bits between the alignment and range fields never affect the result.
    assign w_unused_bits = ^addr[31:2];

    assign fault = w_align_fault | w_range_fault;

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Round-robin arbiter/sequencer sharing one RAM port between
//             instruction fetch and load/store, with registered responses.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int MEM_WORDS_LOG2 = 11
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_err,

    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [1:0]  mem_mask,
    input  logic        mem_signed,
    input  logic [31:0] mem_wdata,
    output logic        mem_gnt,
    output logic        mem_rvalid,
    output logic [31:0] mem_rdata,
    output logic        mem_err,

    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [1:0]  ram_mask,
    output logic        ram_signed_ext,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    state_t      r_state;
    state_t      w_next_state;
    logic        r_last_mem;
    logic [31:0] r_resp_data;
    logic        r_resp_err;
    logic        r_resp_sel;

    logic        w_if_gnt;
    logic        w_mem_gnt;
    logic        w_gnt_any;
    logic        w_store;
    logic [31:0] w_sel_addr;
    logic [1:0]  w_sel_mask;
    logic        w_fault;
    logic        w_resp;

    // Grant only while out of reset so an asserted rst_n keeps every output low.
    always_comb begin
        w_next_state = r_state;
        w_if_gnt     = 1'b0;
        w_mem_gnt    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (rst_n) begin
                    if (if_req && mem_req) begin
                        w_if_gnt  = r_last_mem;
                        w_mem_gnt = ~r_last_mem;
                    end else begin
                        w_if_gnt  = if_req;
                        w_mem_gnt = mem_req;
                    end
                end
                if (w_if_gnt || w_mem_gnt) begin
                    w_next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign w_gnt_any  = w_if_gnt | w_mem_gnt;
    assign w_store    = w_mem_gnt & mem_we;
    assign w_sel_addr = w_mem_gnt ? mem_addr : if_addr;
    assign w_sel_mask = w_mem_gnt ? mem_mask : MASK_WORD;

    mem_align_check #(
        .MEM_WORDS_LOG2 (MEM_WORDS_LOG2)
    ) u_align_check (
        .addr  (w_sel_addr),
        .mask  (w_sel_mask),
        .fault (w_fault)
    );

    always_comb begin
        ram_we         = 1'b0;
        ram_addr       = 32'd0;
        ram_mask       = MASK_BYTE;
        ram_signed_ext = 1'b0;
        ram_wdata      = 32'd0;
        if (w_if_gnt) begin
            ram_addr = if_addr;
            ram_mask = MASK_WORD;
        end else if (w_mem_gnt) begin
            ram_we         = mem_we & ~w_fault;
            ram_addr       = mem_addr;
            ram_mask       = mem_mask;
            ram_signed_ext = mem_signed;
            ram_wdata      = mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_mem  <= 1'b0;
            r_resp_data <= 32'd0;
            r_resp_err  <= 1'b0;
            r_resp_sel  <= 1'b0;
        end else if (w_gnt_any) begin
            r_last_mem  <= w_mem_gnt;
            r_resp_data <= (w_store || w_fault) ? 32'd0 : ram_rdata;
            r_resp_err  <= w_fault;
            r_resp_sel  <= w_mem_gnt;
        end
    end

    assign w_resp     = (r_state == ST_RESP);
    assign if_gnt     = w_if_gnt;
    assign mem_gnt    = w_mem_gnt;
    assign if_rvalid  = w_resp & ~r_resp_sel;
    assign mem_rvalid = w_resp & r_resp_sel;
    assign if_rdata   = {32{if_rvalid}} & r_resp_data;
    assign mem_rdata  = {32{mem_rvalid}} & r_resp_data;
    assign if_err     = if_rvalid & r_resp_err;
    assign mem_err    = mem_rvalid & r_resp_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_port_arbiter
//  Purpose  : Directed self-checking bench for mem_port_arbiter with a
//             behavioural byte-masked RAM.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        if_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [1:0]  mem_mask;
    logic        mem_signed;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        mem_err;
    logic        ram_we;
    logic [31:0] ram_addr;
    logic [1:0]  ram_mask;
    logic        ram_signed_ext;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    int n_cmp;
    int n_err;

    mem_port_arbiter #(
        .MEM_WORDS_LOG2 (11)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .if_req         (if_req),
        .if_addr        (if_addr),
        .if_gnt         (if_gnt),
        .if_rvalid      (if_rvalid),
        .if_rdata       (if_rdata),
        .if_err         (if_err),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_mask       (mem_mask),
        .mem_signed     (mem_signed),
        .mem_wdata      (mem_wdata),
        .mem_gnt        (mem_gnt),
        .mem_rvalid     (mem_rvalid),
        .mem_rdata      (mem_rdata),
        .mem_err        (mem_err),
        .ram_we         (ram_we),
        .ram_addr       (ram_addr),
        .ram_mask       (ram_mask),
        .ram_signed_ext (ram_signed_ext),
        .ram_wdata      (ram_wdata),
        .ram_rdata      (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: combinational extended read, synchronous masked write.
    logic [31:0] ram [0:2047];
    logic [31:0] w_word;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_word    = ram[ram_addr[12:2]];
        w_byte    = w_word[8*ram_addr[1:0] +: 8];
        w_half    = w_word[16*ram_addr[1] +: 16];
        ram_rdata = w_word;
        if (ram_mask == 2'b00) begin
            ram_rdata = ram_signed_ext ? {{24{w_byte[7]}}, w_byte} : {24'd0, w_byte};
        end else if (ram_mask == 2'b01) begin
            ram_rdata = ram_signed_ext ? {{16{w_half[15]}}, w_half} : {16'd0, w_half};
        end
    end

    always @(posedge clk) begin
        if (ram_we) begin
            if (ram_mask == 2'b00) begin
                ram[ram_addr[12:2]][8*ram_addr[1:0] +: 8] <= ram_wdata[7:0];
            end else if (ram_mask == 2'b01) begin
                ram[ram_addr[12:2]][16*ram_addr[1] +: 16] <= ram_wdata[15:0];
            end else begin
                ram[ram_addr[12:2]] <= ram_wdata;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req     = 1'b0;
        if_addr    = 32'd0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = 32'd0;
        mem_mask   = 2'b10;
        mem_signed = 1'b0;
        mem_wdata  = 32'd0;
    endtask

    // One MEM transaction from an IDLE cycle: grant now, response next cycle.
    task automatic mem_access(input string tag, input logic we, input logic [31:0] addr,
                              input logic [1:0] mask, input logic sgn, input logic [31:0] wdata,
                              input logic exp_we, input logic [31:0] exp_rdata, input logic exp_err);
        mem_req    = 1'b1;
        mem_we     = we;
        mem_addr   = addr;
        mem_mask   = mask;
        mem_signed = sgn;
        mem_wdata  = wdata;
        #1;
        check({tag, "_gnt"}, {31'd0, mem_gnt}, 32'd1);
        check({tag, "_ram_we"}, {31'd0, ram_we}, {31'd0, exp_we});
        tick();
        idle_inputs();
        check({tag, "_rvalid"}, {30'd0, if_rvalid, mem_rvalid}, 32'd1);
        check({tag, "_ram_we_resp"}, {31'd0, ram_we}, 32'd0);
        check({tag, "_rdata"}, mem_rdata, exp_rdata);
        check({tag, "_err"}, {31'd0, mem_err}, {31'd0, exp_err});
        tick();
    endtask

    logic [3:0] exp_strobe [0:7];

    initial begin
        n_cmp = 0;
        n_err = 0;
        for (int i = 0; i < 2048; i++) ram[i] = 32'd0;
        ram[0] = 32'h1122_3344;
        ram[4] = 32'hDEAD_BEEF;
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();

        check("rst_strobes", {25'd0, if_gnt, mem_gnt, if_rvalid, mem_rvalid, if_err, mem_err, ram_we}, 32'd0);
        check("rst_if_rdata", if_rdata, 32'd0);
        check("rst_mem_rdata", mem_rdata, 32'd0);
        check("rst_ram_addr", ram_addr, 32'd0);
        rst_n = 1'b1;
        tick();

        // IF fetch alone
        if_req  = 1'b1;
        if_addr = 32'h10;
        #1;
        check("if_gnt", {30'd0, if_gnt, mem_gnt}, 32'd2);
        check("if_ram_addr", ram_addr, 32'h10);
        check("if_ram_mask", {30'd0, ram_mask}, 32'd2);
        tick();
        if_req = 1'b0;
        check("if_rvalid", {30'd0, if_rvalid, mem_rvalid}, 32'd2);
        check("if_rdata", if_rdata, 32'hDEAD_BEEF);
        check("if_err", {31'd0, if_err}, 32'd0);
        check("if_no_gnt_in_resp", {30'd0, if_gnt, mem_gnt}, 32'd0);
        tick();

        // Byte store then signed and unsigned byte loads
        mem_access("st_b", 1'b1, 32'h21, 2'b00, 1'b0, 32'h0000_00A5, 1'b1, 32'd0, 1'b0);
        mem_access("ld_bs", 1'b0, 32'h21, 2'b00, 1'b1, 32'd0, 1'b0, 32'hFFFF_FFA5, 1'b0);
        mem_access("ld_bu", 1'b0, 32'h21, 2'b00, 1'b0, 32'd0, 1'b0, 32'h0000_00A5, 1'b0);
        mem_access("ld_w20", 1'b0, 32'h20, 2'b10, 1'b0, 32'd0, 1'b0, 32'h0000_A500, 1'b0);

        // Faults
        mem_access("st_h_mis", 1'b1, 32'h3, 2'b01, 1'b0, 32'h0000_FFFF, 1'b0, 32'd0, 1'b1);
        mem_access("ld_w0", 1'b0, 32'h0, 2'b10, 1'b0, 32'd0, 1'b0, 32'h1122_3344, 1'b0);
        mem_access("ld_oor", 1'b0, 32'h8000, 2'b10, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
        mem_access("ld_top", 1'b0, 32'h1FFC, 2'b10, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
        if_req  = 1'b1;
        if_addr = 32'h12;
        tick();
        if_req = 1'b0;
        check("if_mis_err", {30'd0, if_err, mem_err}, 32'd2);
        check("if_mis_rdata", if_rdata, 32'd0);
        tick();

        // Both requesting continuously from reset
        rst_n = 1'b0;
        tick();
        if_req   = 1'b1;
        if_addr  = 32'h10;
        mem_req  = 1'b1;
        mem_addr = 32'h0;
        mem_mask = 2'b10;
        #1;
        check("conf_gated_in_rst", {30'd0, if_gnt, mem_gnt}, 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        exp_strobe[0] = 4'b0100;
        exp_strobe[1] = 4'b0001;
        exp_strobe[2] = 4'b1000;
        exp_strobe[3] = 4'b0010;
        exp_strobe[4] = 4'b0100;
        exp_strobe[5] = 4'b0001;
        exp_strobe[6] = 4'b1000;
        exp_strobe[7] = 4'b0010;
        for (int c = 0; c < 8; c++) begin
            if (c != 0) tick();
            check($sformatf("conf_c%0d_strobes", c), {28'd0, if_gnt, mem_gnt, if_rvalid, mem_rvalid},
                  {28'd0, exp_strobe[c]});
            check($sformatf("conf_c%0d_if_rdata", c), if_rdata, exp_strobe[c][1] ? 32'hDEAD_BEEF : 32'd0);
            check($sformatf("conf_c%0d_mem_rdata", c), mem_rdata, exp_strobe[c][0] ? 32'h1122_3344 : 32'd0);
        end
        idle_inputs();
        tick();

        // Reset asserted during the response cycle of a load
        mem_req  = 1'b1;
        mem_addr = 32'h0;
        #1;
        check("rst_mid_gnt", {31'd0, mem_gnt}, 32'd1);
        tick();
        mem_req = 1'b0;
        rst_n   = 1'b0;
        #1;
        check("rst_mid_strobes", {25'd0, if_gnt, mem_gnt, if_rvalid, mem_rvalid, if_err, mem_err, ram_we}, 32'd0);
        check("rst_mid_rdata", mem_rdata, 32'd0);
        tick();
        check("rst_mid_hold", {30'd0, if_rvalid, mem_rvalid}, 32'd0);
        if_req  = 1'b1;
        if_addr = 32'h10;
        tick();
        rst_n = 1'b1;
        #1;
        check("post_rst_if_gnt", {30'd0, if_gnt, mem_gnt}, 32'd2);
        tick();
        if_req = 1'b0;
        check("post_rst_if_rdata", if_rdata, 32'hDEAD_BEEF);
        check("post_rst_no_mem", {31'd0, mem_rvalid}, 32'd0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
